// File: rtl/collatz_sweep_if.sv
// Host, collatz-core and result-stream signals of the collatz sweep controller,
// bundled so the controller and its environment connect through one port.
interface collatz_sweep_if #(
    parameter int STEP_W = 16
);
    logic              start;
    logic [31:0]       first;
    logic [15:0]       count;
    logic              busy;
    logic              sweep_done;
    logic [31:0]       best_n;
    logic [STEP_W-1:0] best_steps;

    logic              core_go;
    logic [31:0]       core_n;
    logic [31:0]       core_dout;
    logic              core_done;

    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_n;
    logic [STEP_W-1:0] res_steps;
    logic              res_timeout;

    modport slave (
        input  start, first, count, core_dout, core_done, res_ready,
        output busy, sweep_done, best_n, best_steps,
               core_go, core_n,
               res_valid, res_n, res_steps, res_timeout
    );

    modport master (
        output start, first, count, core_dout, core_done, res_ready,
        input  busy, sweep_done, best_n, best_steps,
               core_go, core_n,
               res_valid, res_n, res_steps, res_timeout
    );
endinterface

// File: rtl/collatz_sweep.sv
// Sweep controller: launches the collatz core on each start value of a range,
// streams one step-count result per value and tracks the longest trajectory.
module collatz_sweep #(
    parameter int STEP_W    = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic            clk,
    input  logic            reset_n,
    collatz_sweep_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, EMIT, FINISH} state_t;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);
    localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEPS);

    state_t            state_q, state_d;
    logic [31:0]       cur_n_q, cur_n_d;
    logic [15:0]       remaining_q, remaining_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              busy_q, busy_d;
    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_n_q, res_n_d;
    logic [STEP_W-1:0] res_steps_q, res_steps_d;
    logic              res_timeout_q, res_timeout_d;
    logic [31:0]       best_n_q, best_n_d;
    logic [STEP_W-1:0] best_steps_q, best_steps_d;
    logic              core_go;
    logic              sweep_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cur_n_q       <= '0;
            remaining_q   <= '0;
            steps_q       <= '0;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_n_q       <= '0;
            res_steps_q   <= '0;
            res_timeout_q <= 1'b0;
            best_n_q      <= '0;
            best_steps_q  <= '0;
        end else begin
            state_q       <= state_d;
            cur_n_q       <= cur_n_d;
            remaining_q   <= remaining_d;
            steps_q       <= steps_d;
            busy_q        <= busy_d;
            res_valid_q   <= res_valid_d;
            res_n_q       <= res_n_d;
            res_steps_q   <= res_steps_d;
            res_timeout_q <= res_timeout_d;
            best_n_q      <= best_n_d;
            best_steps_q  <= best_steps_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_n_d       = cur_n_q;
        remaining_d   = remaining_q;
        steps_d       = steps_q;
        busy_d        = busy_q;
        res_valid_d   = res_valid_q;
        res_n_d       = res_n_q;
        res_steps_d   = res_steps_q;
        res_timeout_d = res_timeout_q;
        best_n_d      = best_n_q;
        best_steps_d  = best_steps_q;
        core_go       = 1'b0;
        sweep_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cur_n_d      = bus.first;
                    remaining_d  = bus.count;
                    best_n_d     = '0;
                    best_steps_d = '0;
                    if (bus.count != 16'd0) begin
                        state_d = LAUNCH;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            LAUNCH: begin
                core_go = 1'b1;
                steps_d = '0;
                state_d = RUN;
            end
            // core_dout already holds the start value in the first RUN cycle,
            // so a done seen with steps_q=S means S iterations were needed.
            RUN: begin
                if (bus.core_done) begin
                    res_steps_d   = steps_q;
                    res_timeout_d = 1'b0;
                    res_n_d       = cur_n_q;
                    res_valid_d   = 1'b1;
                    state_d       = EMIT;
                end else if (steps_q == STEP_LAST) begin
                    res_steps_d   = STEP_MAX;
                    res_timeout_d = 1'b1;
                    res_n_d       = cur_n_q;
                    res_valid_d   = 1'b1;
                    state_d       = EMIT;
                end else begin
                    steps_d = steps_q + STEP_W'(1);
                end
            end
            EMIT: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    cur_n_d     = cur_n_q + 32'd1;
                    remaining_d = remaining_q - 16'd1;
                    if (!res_timeout_q && (res_steps_q > best_steps_q)) begin
                        best_n_d     = res_n_q;
                        best_steps_d = res_steps_q;
                    end
                    state_d = (remaining_q != 16'd1) ? LAUNCH : FINISH;
                end
            end
            FINISH: begin
                sweep_done = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.core_go     = core_go;
    assign bus.core_n      = cur_n_q;
    assign bus.busy        = busy_q;
    assign bus.sweep_done  = sweep_done;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_n       = res_n_q;
    assign bus.res_steps   = res_steps_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.best_n      = best_n_q;
    assign bus.best_steps  = best_steps_q;
endmodule

// File: tb/tb_collatz_sweep.sv
// Directed bench for collatz_sweep: a behavioural collatz core, a table of
// single-value sweeps and hand-written multi-cycle sequences.
module tb_collatz_sweep;
    localparam int STEP_W    = 16;
    localparam int MAX_STEPS = 1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    collatz_sweep_if #(.STEP_W(STEP_W)) bus ();

    collatz_sweep #(.STEP_W(STEP_W), .MAX_STEPS(MAX_STEPS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Core loads n on the go edge, then advances one collatz step per cycle.
    logic [31:0] coreVal = 32'd0;
    always @(posedge clk) begin
        if (bus.core_go)     coreVal <= bus.core_n;
        else if (coreVal[0]) coreVal <= coreVal * 32'd3 + 32'd1;
        else                 coreVal <= coreVal >> 1;
    end
    assign bus.core_dout = coreVal;
    assign bus.core_done = (coreVal == 32'd1);

    logic [31:0] gotN[$];
    logic [15:0] gotSteps[$];
    logic        gotTo[$];
    int doneCount = 0;
    int goCount   = 0;
    int checks    = 0;
    int failures  = 0;

    always @(negedge clk) begin
        if (bus.res_valid && bus.res_ready) begin
            gotN.push_back(bus.res_n);
            gotSteps.push_back(bus.res_steps);
            gotTo.push_back(bus.res_timeout);
        end
        if (bus.sweep_done) doneCount++;
        if (bus.core_go)    goCount++;
    end

    typedef struct {
        logic [31:0] n;
        logic [15:0] steps;
        logic        timeout;
    } vec_t;

    vec_t vecs[8];
    logic [15:0] sweepSteps[10];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearResults();
        gotN.delete();
        gotSteps.delete();
        gotTo.delete();
    endtask

    // Called at posedge+1; start is sampled on the following posedge.
    task automatic applyStimulus(input logic [31:0] f, input logic [15:0] c);
        bus.first = f;
        bus.count = c;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic waitSweepDone(input int maxCycles);
        int n = 0;
        while (!bus.sweep_done && n < maxCycles) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("sweep_done_seen", 64'(bus.sweep_done), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic waitValid(input int maxCycles, output int cyc);
        cyc = 0;
        while (!bus.res_valid && cyc < maxCycles) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("res_valid_seen", 64'(bus.res_valid), 64'd1);
    endtask

    initial begin
        int lat;
        int doneBefore;
        int goBefore;
        logic [31:0] expBestN;
        logic [15:0] expBestSteps;

        vecs[0] = '{32'd6,  16'd8,    1'b0};
        vecs[1] = '{32'd1,  16'd0,    1'b0};
        vecs[2] = '{32'd2,  16'd1,    1'b0};
        vecs[3] = '{32'd3,  16'd7,    1'b0};
        vecs[4] = '{32'd7,  16'd16,   1'b0};
        vecs[5] = '{32'd9,  16'd19,   1'b0};
        vecs[6] = '{32'd27, 16'd111,  1'b0};
        vecs[7] = '{32'd0,  16'd1000, 1'b1};
        sweepSteps = '{16'd0, 16'd1, 16'd7, 16'd2, 16'd5, 16'd8, 16'd16, 16'd3, 16'd19, 16'd6};

        bus.start     = 1'b0;
        bus.first     = 32'd0;
        bus.count     = 16'd0;
        bus.res_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
            {bus.core_go, bus.res_valid, bus.res_timeout, bus.busy, bus.sweep_done, bus.res_n},
            64'd0);
        checkOutput("reset_best", {bus.best_n, bus.best_steps, bus.res_steps}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // n=6: LAUNCH + 9 RUN cycles, so res_valid is up 10 edges after the start edge.
        clearResults();
        applyStimulus(32'd6, 16'd1);
        checkOutput("busy_after_start", 64'(bus.busy), 64'd1);
        waitValid(50, lat);
        checkOutput("latency_n6", 64'(lat), 64'd10);
        checkOutput("res_n6", {bus.res_n, 16'(bus.res_steps), 15'd0, bus.res_timeout}, {32'd6, 16'd8, 16'd0});
        @(posedge clk); #1;
        checkOutput("sweep_done_after_accept", 64'(bus.sweep_done), 64'd1);
        @(posedge clk); #1;
        checkOutput("sweep_done_one_cycle", {bus.sweep_done, bus.busy}, 64'd0);
        checkOutput("best_n6", {bus.best_n, 16'(bus.best_steps)}, {32'd6, 16'd8});

        for (int i = 0; i < 8; i++) begin
            clearResults();
            doneBefore = doneCount;
            applyStimulus(vecs[i].n, 16'd1);
            waitSweepDone(MAX_STEPS + 100);
            checkOutput($sformatf("vec%0d_count", i), 64'(gotN.size()), 64'd1);
            if (gotN.size() > 0) begin
                checkOutput($sformatf("vec%0d_n", i), 64'(gotN[0]), 64'(vecs[i].n));
                checkOutput($sformatf("vec%0d_steps", i), 64'(gotSteps[0]), 64'(vecs[i].steps));
                checkOutput($sformatf("vec%0d_timeout", i), 64'(gotTo[0]), 64'(vecs[i].timeout));
            end
            expBestN     = (!vecs[i].timeout && vecs[i].steps != 16'd0) ? vecs[i].n : 32'd0;
            expBestSteps = (!vecs[i].timeout) ? vecs[i].steps : 16'd0;
            checkOutput($sformatf("vec%0d_best", i), {bus.best_n, 16'(bus.best_steps)}, {expBestN, expBestSteps});
            checkOutput($sformatf("vec%0d_done_pulses", i), 64'(doneCount - doneBefore), 64'd1);
        end

        clearResults();
        doneBefore = doneCount;
        goBefore   = goCount;
        applyStimulus(32'd1, 16'd10);
        waitSweepDone(2000);
        checkOutput("sweep10_count", 64'(gotN.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (gotN.size() > i) begin
                checkOutput($sformatf("sweep10_r%0d", i), {gotN[i], gotSteps[i], 15'd0, gotTo[i]},
                            {32'(i + 1), sweepSteps[i], 16'd0});
            end
        end
        checkOutput("sweep10_best", {bus.best_n, 16'(bus.best_steps)}, {32'd9, 16'd19});
        checkOutput("sweep10_done_pulses", 64'(doneCount - doneBefore), 64'd1);
        checkOutput("sweep10_go_pulses", 64'(goCount - goBefore), 64'd10);

        // Back-pressure: each result must sit unchanged through a 5-cycle stall.
        clearResults();
        bus.res_ready = 1'b0;
        applyStimulus(32'd3, 16'd2);
        for (int r = 0; r < 2; r++) begin
            waitValid(100, lat);
            for (int s = 0; s < 5; s++) begin
                checkOutput($sformatf("stall_r%0d_c%0d", r, s),
                    {15'd0, bus.res_valid, bus.res_n, 16'(bus.res_steps)},
                    {16'd1, (r == 0) ? 32'd3 : 32'd4, (r == 0) ? 16'd7 : 16'd2});
                @(posedge clk); #1;
            end
            bus.res_ready = 1'b1;
            @(posedge clk); #1;
            bus.res_ready = 1'b0;
        end
        bus.res_ready = 1'b1;
        waitSweepDone(20);
        checkOutput("stall_count", 64'(gotN.size()), 64'd2);
        if (gotN.size() == 2) begin
            checkOutput("stall_seq", {gotN[0], gotN[1]}, {32'd3, 32'd4});
        end
        checkOutput("stall_best", {bus.best_n, 16'(bus.best_steps)}, {32'd3, 16'd7});

        clearResults();
        goBefore = goCount;
        applyStimulus(32'h55, 16'd0);
        checkOutput("count0_done", {bus.sweep_done, bus.busy}, {63'd0, 1'b1} << 1);
        checkOutput("count0_best", {bus.best_n, 16'(bus.best_steps)}, 64'd0);
        @(posedge clk); #1;
        checkOutput("count0_done_clear", 64'(bus.sweep_done), 64'd0);
        checkOutput("count0_no_activity", {32'(goCount - goBefore), 32'(gotN.size())}, 64'd0);

        clearResults();
        applyStimulus(32'd6, 16'd2);
        repeat (3) @(posedge clk);
        #1;
        bus.first = 32'd100;
        bus.count = 16'd5;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waitSweepDone(200);
        checkOutput("midstart_count", 64'(gotN.size()), 64'd2);
        if (gotN.size() == 2) begin
            checkOutput("midstart_seq", {gotN[0], gotSteps[0], gotN[1][15:0], gotSteps[1]},
                        {32'd6, 16'd8, 16'd7, 16'd16});
        end
        checkOutput("midstart_best", {bus.best_n, 16'(bus.best_steps)}, {32'd7, 16'd16});

        clearResults();
        applyStimulus(32'hFFFF_FFFF, 16'd2);
        waitSweepDone(2 * MAX_STEPS + 100);
        checkOutput("wrap_count", 64'(gotN.size()), 64'd2);
        if (gotN.size() == 2) begin
            checkOutput("wrap_n", {gotN[0], gotN[1]}, {32'hFFFF_FFFF, 32'd0});
            checkOutput("wrap_zero_timeout", {gotSteps[1], 15'd0, gotTo[1]}, {16'd1000, 16'd1});
        end

        clearResults();
        doneBefore = doneCount;
        applyStimulus(32'd27, 16'd3);
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_outputs",
            {bus.core_go, bus.res_valid, bus.res_timeout, bus.busy, bus.sweep_done, bus.res_n},
            64'd0);
        checkOutput("midreset_best", {bus.best_n, bus.best_steps, bus.res_steps}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_silent", {32'(doneCount - doneBefore), 32'(gotN.size())}, 64'd0);
        applyStimulus(32'd2, 16'd1);
        waitSweepDone(50);
        checkOutput("after_reset_count", 64'(gotN.size()), 64'd1);
        if (gotN.size() == 1) begin
            checkOutput("after_reset_result", {gotN[0], gotSteps[0]}, {32'd2, 16'd1});
        end
        checkOutput("after_reset_best", {bus.best_n, 16'(bus.best_steps)}, {32'd2, 16'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/collatz_sweep.md
Name: collatz_sweep

Overview:
- Upstream controller for the collatz iteration core.
- Walks a range of start values `first .. first+count-1`. For each value it pulses the core's `go`, counts core iterations until `done`, and emits one result per value on a valid/ready stream.
- Tracks the start value with the longest trajectory across the sweep.
- Sits between a host/register interface and one collatz core instance.

Parameters:
- STEP_W, 16, width of step counters and step outputs.
- MAX_STEPS, 1000, iteration limit per value. Reaching it aborts that value with a timeout flag.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a sweep; ignored while busy=1
- first  input  32  first start value; sampled when start accepted
- count  input  16  number of values to sweep; sampled when start accepted
- core_go  output  1  to core go
- core_n  output  32  to core n; valid when core_go=1
- core_dout  input  32  from core dout
- core_done  input  1  from core done (dout==1)
- res_valid  output  1  per-value result valid
- res_ready  input  1  consumer accepts result
- res_n  output  32  start value of this result
- res_steps  output  STEP_W  iterations to reach 1
- res_timeout  output  1  value hit MAX_STEPS without reaching 1
- busy  output  1  sweep in progress
- sweep_done  output  1  one-cycle pulse at sweep end
- best_n  output  32  start value with most steps in last/current sweep
- best_steps  output  STEP_W  that step count

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE.
  - core_go, res_valid, res_timeout, busy and sweep_done are 0.
  - res_n, res_steps, best_n and best_steps are 0.
  - Reset mid-sweep abandons the sweep silently: no sweep_done, no pending result.
- IDLE:
  - start=1 latches cur_n<=first and remaining<=count, and clears best_n/best_steps to 0.
  - count!=0: go to LAUNCH and set busy=1.
  - count==0: go to FINISH.
- LAUNCH (1 cycle):
  - core_go=1, core_n=cur_n.
  - steps<=0.
  - Go to RUN.
- RUN: each cycle, core_dout holds the current iterate.
  - core_done=1: latch res_steps=steps, res_timeout=0, res_n=cur_n, res_valid<=1, go to EMIT.
  - Else if steps==MAX_STEPS-1: latch res_steps=MAX_STEPS, res_timeout=1, res_valid<=1, go to EMIT.
  - Else: steps<=steps+1.
- Latency: a value needing S iterations occupies 1 LAUNCH + (S+1) RUN cycles before res_valid rises. Example: n=6 gives 8 steps, 9 RUN cycles, res_valid in the 11th cycle after leaving IDLE.
- EMIT:
  - res_* are registered and held stable while res_valid=1 and res_ready=0.
  - On res_valid&res_ready: res_valid<=0, cur_n<=cur_n+1 (mod 2^32, wraps FFFFFFFF→0), remaining<=remaining-1.
  - If remaining-1 != 0: go to LAUNCH, else FINISH.
  - res_ready ignored when res_valid=0.
- Best tracking, on result acceptance:
  - res_timeout=0 and res_steps > best_steps (strict): best_n<=res_n, best_steps<=res_steps.
  - Ties keep the earlier value.
  - Timeouts never update best.
  - Caveat: best_steps clears to 0 and update is strict >, so with the clear-to-0 rule best_n stays 0 for a sweep containing only n=1 (0 steps).
- FINISH (1 cycle):
  - sweep_done=1, busy=0 next, go to IDLE.
  - best_* hold until the next accepted start.
- start asserted in any non-IDLE state: no effect.
- n=0: core stays at 0 and never reaches 1, so the value must time out.
- Core has no reset, so core_dout is never consulted before a LAUNCH.

Test Plan:
- first=6, count=1, res_ready=1 → single result res_n=6, res_steps=8, timeout=0, res_valid first high 11 cycles after start; sweep_done one cycle after acceptance; best_n=6, best_steps=8.
- first=1, count=10, res_ready=1 → steps 0,1,7,2,5,8,16,3,19,6 in order; best_n=9, best_steps=19; exactly one sweep_done pulse.
- first=0, count=1, MAX_STEPS=1000 → res_steps=1000, res_timeout=1; best_n=0, best_steps=0.
- first=3, count=2, res_ready held low 5 cycles per result → res_valid/res_n/res_steps stable while stalled; results (3,7) then (4,2); no dropped or duplicated results.
- count=0 start → no core_go, no res_valid, sweep_done pulses 1 cycle later, best cleared to 0. Also: start pulsed mid-sweep → ignored, sweep unchanged.
- reset_n low during RUN of first=27, count=3 → all outputs 0 immediately; no sweep_done. A new start with first=2, count=1 then gives res_steps=1.
